seg7_scan3: RTL and testbench



---
 rtl/seg7_scan3.sv | 144 ++++++++++++++
 tb/tb_seg7_scan3.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan3.sv
// seg7_scan3: three-digit multiplexed seven-segment driver for a common-anode,
// active-low display. BCD digits are captured on a load strobe into holding
// registers and scanned ones -> tens -> hundreds, one digit per SCAN_DIV cycles.
// Optional feature macro: SEG7_LEADING_ZERO_BLANK_EN (blank leading zeros in
// the hundreds and tens positions; ones is always shown).
module seg7_scan3 #(
  parameter int SCAN_DIV = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [3:0] hundreds,
  input  logic [3:0] tens,
  input  logic [3:0] ones,
  output logic [2:0] an,
  output logic [6:0] seg,
  output logic       frame
);

  localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SCAN_DIV - 1);

  localparam logic [1:0] ST_BLANK    = 2'd0;
  localparam logic [1:0] ST_ONES     = 2'd1;
  localparam logic [1:0] ST_TENS     = 2'd2;
  localparam logic [1:0] ST_HUNDREDS = 2'd3;

  localparam logic [6:0] SEG_OFF = 7'b1111111;

  logic [3:0]       h_q, h_d, t_q, t_d, o_q, o_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick;
  logic [1:0]       state_q, state_d;
  logic [2:0]       an_q, an_d;
  logic [6:0]       seg_q, seg_d;
  logic             frame_q, frame_d;
  logic [3:0]       digit_sel;
  logic             blank_sel;

  // BCD to active-low {g,f,e,d,c,b,a}; non-decimal codes show a dash.
  function automatic logic [6:0] decode(input logic [3:0] d);
    case (d)
      4'd0:    decode = 7'b1000000;
      4'd1:    decode = 7'b1111001;
      4'd2:    decode = 7'b0100100;
      4'd3:    decode = 7'b0110000;
      4'd4:    decode = 7'b0011001;
      4'd5:    decode = 7'b0010010;
      4'd6:    decode = 7'b0000010;
      4'd7:    decode = 7'b1111000;
      4'd8:    decode = 7'b0000000;
      4'd9:    decode = 7'b0010000;
      default: decode = 7'b0111111;
    endcase
  endfunction

  // Holding registers follow the inputs only on a load strobe.
  always_comb begin
    h_d = load ? hundreds : h_q;
    t_d = load ? tens     : t_q;
    o_d = load ? ones     : o_q;
  end

  // Prescaler: free-running 0..SCAN_DIV-1, tick on the terminal count.
  always_comb begin
    tick  = (cnt_q == CNT_MAX);
    cnt_d = tick ? '0 : cnt_q + 1'b1;
  end

  // Scan sequencer: on each tick advance the digit and register the outputs
  // for the newly selected digit from the current (pre-load) holding values.
  always_comb begin
    // NOTE: every signal gets a default before the branches so no path leaves
    // it unassigned; otherwise synthesis infers a latch.
    state_d   = state_q;
    an_d      = an_q;
    seg_d     = seg_q;
    frame_d   = 1'b0;
    digit_sel = o_q;
    blank_sel = 1'b0;
    if (tick) begin
      case (state_q)
        ST_BLANK: state_d = ST_ONES;
        ST_ONES:  state_d = ST_TENS;
        ST_TENS:  state_d = ST_HUNDREDS;
        default:  state_d = ST_ONES;
      endcase
      frame_d = (state_q == ST_HUNDREDS);
      case (state_d)
        ST_TENS: begin
          an_d      = 3'b101;
          digit_sel = t_q;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
          blank_sel = (h_q == 4'd0) && (t_q == 4'd0);
`endif
        end
        ST_HUNDREDS: begin
          an_d      = 3'b011;
          digit_sel = h_q;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
          blank_sel = (h_q == 4'd0);
`endif
        end
        default: begin
          an_d      = 3'b110;
          digit_sel = o_q;
        end
      endcase
      seg_d = blank_sel ? SEG_OFF : decode(digit_sel);
    end
  end

  // State and output registers; reset blanks the display immediately.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: non-blocking assignments make every flop sample the pre-edge
    // values, so the order of statements here does not matter.
    if (rst) begin
      // NOTE: the holding registers are plain flops, not a memory array, so
      // they reset cleanly to a known 000 display value.
      h_q     <= 4'd0;
      t_q     <= 4'd0;
      o_q     <= 4'd0;
      cnt_q   <= '0;
      state_q <= ST_BLANK;
      an_q    <= 3'b111;
      seg_q   <= SEG_OFF;
      frame_q <= 1'b0;
    end else begin
      h_q     <= h_d;
      t_q     <= t_d;
      o_q     <= o_d;
      cnt_q   <= cnt_d;
      state_q <= state_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
      frame_q <= frame_d;
    end
  end

  assign an    = an_q;
  assign seg   = seg_q;
  assign frame = frame_q;

endmodule

// File: tb/tb_seg7_scan3.sv
// tb_seg7_scan3: directed plus randomized checks of seg7_scan3 with SCAN_DIV=4
// against a cycle-count based reference model of the display schedule.
module tb_seg7_scan3;

  localparam int SD = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       load;
  logic [3:0] hundreds, tens, ones;
  logic [2:0] an;
  logic [6:0] seg;
  logic       frame;

  seg7_scan3 #(.SCAN_DIV(SD)) dut (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .hundreds (hundreds),
    .tens     (tens),
    .ones     (ones),
    .an       (an),
    .seg      (seg),
    .frame    (frame)
  );

  always #5 clk = ~clk;

  localparam logic [6:0] DEC [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0111111, 7'b0111111,
    7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111
  };

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: edges since reset release and the captured digits
  // (index 0 = ones, 1 = tens, 2 = hundreds).
  int         n_edges;
  logic [3:0] hold [3];
  logic [2:0] exp_an;
  logic [6:0] exp_seg;
  logic       exp_frame;

  task automatic check(input string tag, input logic [10:0] obs, input logic [10:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b required %b", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    n_edges   = 0;
    hold[0]   = 4'd0;
    hold[1]   = 4'd0;
    hold[2]   = 4'd0;
    exp_an    = 3'b111;
    exp_seg   = 7'b1111111;
    exp_frame = 1'b0;
  endtask

  function automatic logic [6:0] slot_seg(input int slot);
    logic blank;
    blank = 1'b0;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    if (slot == 2) blank = (hold[2] == 4'd0);
    if (slot == 1) blank = (hold[2] == 4'd0) && (hold[1] == 4'd0);
`endif
    return blank ? 7'b1111111 : DEC[hold[slot]];
  endfunction

  // Every SD-th edge after release starts a new slot; slots cycle
  // ones, tens, hundreds, and each return to ones after the first ends a frame.
  task automatic model_edge(input logic ld, input logic [3:0] h, input logic [3:0] t, input logic [3:0] o);
    int k, slot;
    n_edges++;
    exp_frame = 1'b0;
    if (n_edges % SD == 0) begin
      k       = n_edges / SD;
      slot    = (k - 1) % 3;
      exp_an  = ~(3'b001 << slot);
      exp_seg = slot_seg(slot);
      if (k > 1 && slot == 0) exp_frame = 1'b1;
    end
    if (ld) begin
      hold[0] = o;
      hold[1] = t;
      hold[2] = h;
    end
  endtask

  // One clock: drive inputs, advance the model at the edge, compare 1 ns later.
  task automatic step(input logic ld, input logic [3:0] h, input logic [3:0] t, input logic [3:0] o);
    load = ld; hundreds = h; tens = t; ones = o;
    @(posedge clk);
    model_edge(ld, h, t, o);
    #1;
    check("scan", {an, seg, frame}, {exp_an, exp_seg, exp_frame});
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) step(1'b0, 4'd0, 4'd0, 4'd0);
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    load = 1'b0;
    #1;
    check("reset_async", {an, seg, frame}, {3'b111, 7'b1111111, 1'b0});
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1;
      check("reset_hold", {an, seg, frame}, {3'b111, 7'b1111111, 1'b0});
    end
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    int  frames;
    bit  found;
    rst = 1'b1; load = 1'b0; hundreds = 4'd0; tens = 4'd0; ones = 4'd0;
    model_reset();

    // Reset, then first tick on the SD-th edge showing 0.
    do_reset(3);
    idle(SD - 1);
    check("pre_tick_blank", {an, seg, frame}, {3'b111, 7'b1111111, 1'b0});
    idle(1);
    check("first_tick", {an, seg, frame}, {3'b110, 7'b1000000, 1'b0});

    // Steady scan of 123 with frame counting.
    do_reset(3);
    step(1'b1, 4'd1, 4'd2, 4'd3);
    frames = 0;
    for (int i = 0; i < 36; i++) begin
      idle(1);
      if (frame) frames++;
    end
    check("frame_count", 11'(frames), 11'd2);

    // Load on the same edge as the tick selecting ones.
    do_reset(2);
    idle(SD - 1);
    step(1'b1, 4'd5, 4'd5, 4'd5);
    check("collision_old", {an, seg}, {3'b110, 7'b1000000});
    idle(3 * SD);
    check("collision_new", {an, seg}, {3'b110, 7'b0010010});

    // Invalid BCD in hundreds.
    step(1'b1, 4'hC, 4'd9, 4'd0);
    idle(6 * SD);

    // Leading zeros (expected behaviour depends on the build macro).
    step(1'b1, 4'd0, 4'd0, 4'd7);
    idle(6 * SD);

    // Mid-scan reset while tens is displayed.
    found = 1'b0;
    for (int i = 0; i < 4 * SD && !found; i++) begin
      if (an == 3'b101) found = 1'b1;
      else idle(1);
    end
    check("wait_tens", {10'd0, found}, 11'd1);
    do_reset(2);
    idle(SD);
    check("restart_tick", {an, seg}, {3'b110, 7'b1000000});

    // Randomized loads, including dash codes and back-to-back strobes.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 2) == 0),
           4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Safety net against a stuck simulation.
  initial begin
    #200000;
    $display("FAIL timeout: observed no finish required finish");
    $fatal(1, "timeout");
  end

endmodule
